// File: rtl/angle_event_scheduler.sv
// Angle-referenced single-pulse scheduler: on each crank tooth, decide whether the target
// angle lies in the tooth now starting, interpolate the delay in clocks, then drive one pulse.
module angle_event_scheduler #(
    parameter int CYCLE_DEG = 720,
    parameter int DIV_BITS  = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    input  logic        synced,
    input  logic [15:0] eng_phase,
    input  logic [15:0] next_tooth_length_deg,
    input  logic [31:0] tooth_period,
    input  logic        enable,
    input  logic [15:0] target_angle,
    input  logic [31:0] duration,
    output logic        out,
    output logic        busy,
    output logic        fired,
    output logic        done,
    output logic        abort,
    output logic        late,
    output logic [31:0] delay_cycles
);

    localparam int                CNT_W     = $clog2(DIV_BITS + 1);
    localparam logic [15:0]       CYC16     = 16'(CYCLE_DEG);
    localparam logic [31:0]       MIN_FIRE  = 32'(DIV_BITS + 2);
    localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DIV_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DIVIDE,
        S_DELAY,
        S_ACTIVE
    } state_t;

    state_t                r_state;
    logic [15:0]           r_phase;
    logic [15:0]           r_tooth;
    logic [31:0]           r_period;
    logic [15:0]           r_target;
    logic [31:0]           r_duration;
    logic [31:0]           r_elapsed;
    logic [DIV_BITS-1:0]   r_quo;
    logic [15:0]           r_rem;
    logic [CNT_W-1:0]      r_div_cnt;
    logic [31:0]           r_act_cnt;
    logic                  r_force;
    logic                  r_out;
    logic                  r_fired;
    logic                  r_done;
    logic                  r_abort;
    logic                  r_late;
    logic [31:0]           r_delay_cycles;

    state_t                w_state_next;
    logic [15:0]           w_phase_next;
    logic [15:0]           w_tooth_next;
    logic [31:0]           w_period_next;
    logic [15:0]           w_target_next;
    logic [31:0]           w_duration_next;
    logic [31:0]           w_elapsed_next;
    logic [DIV_BITS-1:0]   w_quo_next;
    logic [15:0]           w_rem_next;
    logic [CNT_W-1:0]      w_div_cnt_next;
    logic [31:0]           w_act_cnt_next;
    logic                  w_force_next;
    logic                  w_out_next;
    logic                  w_fired_next;
    logic                  w_done_next;
    logic                  w_abort_next;
    logic                  w_late_next;
    logic [31:0]           w_delay_cycles_next;

    logic [15:0]           w_offset;
    logic                  w_params_bad;
    logic [DIV_BITS-1:0]   w_product;
    logic [16:0]           w_trial;
    logic                  w_ge;
    logic [15:0]           w_rem_step;
    logic [DIV_BITS-1:0]   w_quo_step;
    logic                  w_delay_hit;
    logic [31:0]           w_elapsed_inc;
    logic [31:0]           w_pulse_len;

    // Both angles are below CYCLE_DEG when the offset is used, so 16-bit arithmetic cannot wrap.
    assign w_offset     = (r_target >= r_phase) ? (r_target - r_phase)
                                                : (r_target + CYC16 - r_phase);
    assign w_params_bad = (r_target >= CYC16) || (r_phase >= CYC16) || (r_tooth == 16'd0);
    assign w_product    = DIV_BITS'(w_offset) * DIV_BITS'(r_period);

    // Restoring divider: dividend shifts out of r_quo's top while quotient bits shift in below.
    assign w_trial    = {r_rem, r_quo[DIV_BITS-1]};
    assign w_ge       = w_trial >= {1'b0, r_tooth};
    assign w_rem_step = w_ge ? 16'(w_trial - {1'b0, r_tooth}) : w_trial[15:0];
    assign w_quo_step = {r_quo[DIV_BITS-2:0], w_ge};

    // r_elapsed lags the edge count by one, hence the +1 when comparing against the delay.
    assign w_delay_hit   = ({1'b0, r_elapsed} + 33'd1) >= {1'b0, r_delay_cycles};
    assign w_elapsed_inc = (r_elapsed == 32'hFFFF_FFFF) ? r_elapsed : r_elapsed + 32'd1;
    assign w_pulse_len   = (r_duration == 32'd0) ? 32'd1 : r_duration;

    always_comb begin
        w_state_next        = r_state;
        w_phase_next        = r_phase;
        w_tooth_next        = r_tooth;
        w_period_next       = r_period;
        w_target_next       = r_target;
        w_duration_next     = r_duration;
        w_elapsed_next      = w_elapsed_inc;
        w_quo_next          = r_quo;
        w_rem_next          = r_rem;
        w_div_cnt_next      = r_div_cnt;
        w_act_cnt_next      = r_act_cnt;
        w_force_next        = r_force;
        w_out_next          = r_out;
        w_fired_next        = 1'b0;
        w_done_next         = 1'b0;
        w_abort_next        = 1'b0;
        w_late_next         = 1'b0;
        w_delay_cycles_next = r_delay_cycles;

        case (r_state)
            S_IDLE: begin
                if (trigger && synced && enable) begin
                    w_phase_next    = eng_phase;
                    w_tooth_next    = next_tooth_length_deg;
                    w_period_next   = tooth_period;
                    w_target_next   = target_angle;
                    w_duration_next = duration;
                    w_elapsed_next  = 32'd0;
                    w_force_next    = 1'b0;
                    w_state_next    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_params_bad || (w_offset >= r_tooth)) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_quo_next     = w_product;
                    w_rem_next     = 16'd0;
                    w_div_cnt_next = '0;
                    w_force_next   = trigger;
                    w_state_next   = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (r_force) begin
                    w_out_next     = 1'b1;
                    w_fired_next   = 1'b1;
                    w_late_next    = 1'b1;
                    w_act_cnt_next = w_pulse_len;
                    w_force_next   = 1'b0;
                    w_state_next   = S_ACTIVE;
                end else begin
                    w_quo_next     = w_quo_step;
                    w_rem_next     = w_rem_step;
                    w_div_cnt_next = r_div_cnt + CNT_W'(1);
                    w_force_next   = trigger;
                    if (r_div_cnt == LAST_STEP) begin
                        w_delay_cycles_next = w_quo_step[31:0];
                        w_state_next        = S_DELAY;
                    end
                end
            end
            S_DELAY: begin
                if (r_force || w_delay_hit) begin
                    w_out_next     = 1'b1;
                    w_fired_next   = 1'b1;
                    w_late_next    = r_force || (r_delay_cycles < MIN_FIRE);
                    w_act_cnt_next = w_pulse_len;
                    w_force_next   = 1'b0;
                    w_state_next   = S_ACTIVE;
                end else begin
                    w_force_next = trigger;
                end
            end
            S_ACTIVE: begin
                if (r_act_cnt <= 32'd1) begin
                    w_out_next   = 1'b0;
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_act_cnt_next = r_act_cnt - 32'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Losing sync overrides everything an in-flight event was about to do.
        if ((r_state != S_IDLE) && !synced) begin
            w_state_next        = S_IDLE;
            w_out_next          = 1'b0;
            w_fired_next        = 1'b0;
            w_late_next         = 1'b0;
            w_done_next         = 1'b0;
            w_abort_next        = 1'b1;
            w_force_next        = 1'b0;
            w_delay_cycles_next = r_delay_cycles;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_phase        <= '0;
            r_tooth        <= '0;
            r_period       <= '0;
            r_target       <= '0;
            r_duration     <= '0;
            r_elapsed      <= '0;
            r_quo          <= '0;
            r_rem          <= '0;
            r_div_cnt      <= '0;
            r_act_cnt      <= '0;
            r_force        <= 1'b0;
            r_out          <= 1'b0;
            r_fired        <= 1'b0;
            r_done         <= 1'b0;
            r_abort        <= 1'b0;
            r_late         <= 1'b0;
            r_delay_cycles <= '0;
        end else begin
            r_state        <= w_state_next;
            r_phase        <= w_phase_next;
            r_tooth        <= w_tooth_next;
            r_period       <= w_period_next;
            r_target       <= w_target_next;
            r_duration     <= w_duration_next;
            r_elapsed      <= w_elapsed_next;
            r_quo          <= w_quo_next;
            r_rem          <= w_rem_next;
            r_div_cnt      <= w_div_cnt_next;
            r_act_cnt      <= w_act_cnt_next;
            r_force        <= w_force_next;
            r_out          <= w_out_next;
            r_fired        <= w_fired_next;
            r_done         <= w_done_next;
            r_abort        <= w_abort_next;
            r_late         <= w_late_next;
            r_delay_cycles <= w_delay_cycles_next;
        end
    end

    assign out          = r_out;
    assign busy         = (r_state != S_IDLE);
    assign fired        = r_fired;
    assign done         = r_done;
    assign abort        = r_abort;
    assign late         = r_late;
    assign delay_cycles = r_delay_cycles;

endmodule

// File: tb/tb_angle_event_scheduler.sv
// Bench for angle_event_scheduler: directed scenarios plus randomized events, each checked
// cycle by cycle against expected timing derived from the angle arithmetic.
module tb_angle_event_scheduler;

    logic        clk;
    logic        rst;
    logic        trigger;
    logic        synced;
    logic [15:0] eng_phase;
    logic [15:0] next_tooth_length_deg;
    logic [31:0] tooth_period;
    logic        enable;
    logic [15:0] target_angle;
    logic [31:0] duration;
    logic        out;
    logic        busy;
    logic        fired;
    logic        done;
    logic        abort;
    logic        late;
    logic [31:0] delay_cycles;

    int n_total = 0;
    int n_bad   = 0;
    longint exp_dly = 0;

    angle_event_scheduler #(.CYCLE_DEG(720), .DIV_BITS(48)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .trigger               (trigger),
        .synced                (synced),
        .eng_phase             (eng_phase),
        .next_tooth_length_deg (next_tooth_length_deg),
        .tooth_period          (tooth_period),
        .enable                (enable),
        .target_angle          (target_angle),
        .duration              (duration),
        .out                   (out),
        .busy                  (busy),
        .fired                 (fired),
        .done                  (done),
        .abort                 (abort),
        .late                  (late),
        .delay_cycles          (delay_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] out_vec();
        return {out, busy, fired, done, abort, late};
    endfunction

    // kt: edge index (after T0) at which a second trigger is sampled, -1 none, -2 random.
    // ks: edge index at which synced is first sampled low, -1 none, -2 random.
    task automatic run_event(input string name, input int phase, input int tooth,
                             input int target, input int period, input int dur,
                             input int kt_in, input int ks_in, input logic en_after);
        int     offset;
        bit     inwin;
        longint q;
        longint normal;
        longint fire;
        longint fin;
        longint last;
        bit     is_late;
        int     kt;
        int     ks;
        logic [5:0] exp_v;

        inwin  = (target < 720) && (phase < 720) && (tooth != 0);
        offset = (target >= phase) ? target - phase : target + 720 - phase;
        if (inwin && offset >= tooth) inwin = 0;
        q      = inwin ? (longint'(offset) * period) / tooth : 0;
        normal = (q > 50) ? q : 50;
        kt     = kt_in;
        ks     = ks_in;
        if (kt == -2) begin
            kt = -1;
            if (normal >= 60 && ($urandom_range(0, 3) == 0))
                kt = ($urandom_range(0, 1) == 0) ? $urandom_range(2, 40)
                                                 : $urandom_range(51, int'(normal) - 2);
        end
        fire    = (kt > 0) ? kt + 1 : normal;
        is_late = (q < 50) || (kt > 0);
        fin     = fire + ((dur == 0) ? 1 : dur);
        if (ks == -2) ks = ($urandom_range(0, 4) == 0) ? $urandom_range(1, int'(fin) - 1) : -1;
        if (!inwin) begin
            kt = -1;
            ks = -1;
        end
        last = !inwin ? 4 : ((ks > 0) ? ks + 2 : fin + 2);

        @(negedge clk);
        eng_phase             = 16'(phase);
        next_tooth_length_deg = 16'(tooth);
        target_angle          = 16'(target);
        tooth_period          = 32'(period);
        duration              = 32'(dur);
        enable                = 1'b1;
        synced                = 1'b1;
        trigger               = 1'b1;
        @(posedge clk);
        #1;
        check_val({name, "_t0"}, 64'(out_vec()), 64'(6'b010000));

        for (longint k = 1; k <= last; k++) begin
            @(negedge clk);
            trigger               = (k == kt);
            synced                = !((ks > 0) && (k >= ks));
            enable                = en_after;
            eng_phase             = 16'($urandom);
            next_tooth_length_deg = 16'($urandom);
            target_angle          = 16'($urandom);
            tooth_period          = $urandom;
            duration              = $urandom;
            @(posedge clk);
            #1;
            if (ks > 0 && k >= ks)
                exp_v = (k == ks) ? 6'b000010 : 6'b000000;
            else if (!inwin)
                exp_v = 6'b000000;
            else
                exp_v = {(k >= fire && k < fin), (k < fin), (k == fire), (k == fin),
                         1'b0, (k == fire) && is_late};
            check_val($sformatf("%s_k%0d", name, k), 64'(out_vec()), 64'(exp_v));
        end

        if (inwin && !((kt > 0) && (kt + 1 <= 49)) && !((ks > 0) && (ks <= 49)))
            exp_dly = q;
        check_val({name, "_dly"}, 64'(delay_cycles), 64'(exp_dly));
        $display("event %s phase=%0d tooth=%0d target=%0d period=%0d dur=%0d inwin=%0d q=%0d kt=%0d ks=%0d dly=%0d",
                 name, phase, tooth, target, period, dur, inwin, q, kt, ks, delay_cycles);

        @(negedge clk);
        trigger = 1'b0;
        synced  = 1'b1;
        enable  = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        trigger = 1'b0;
        synced = 1'b1;
        enable = 1'b1;
        eng_phase = '0;
        next_tooth_length_deg = '0;
        tooth_period = '0;
        target_angle = '0;
        duration = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_outs", 64'(out_vec()), 64'd0);
        check_val("rst_dly", 64'(delay_cycles), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("post_rst_outs", 64'(out_vec()), 64'd0);

        run_event("basic",    90,  6,  93, 1000, 200, -1, -1, 1'b1);
        check_val("basic_q", 64'(delay_cycles), 64'd500);
        run_event("wrap",     714, 12, 2,  4000, 10,  -1, -1, 1'b1);
        check_val("wrap_q", 64'(delay_cycles), 64'd2666);
        run_event("outside",  90,  6,  96, 1000, 200, -1, -1, 1'b1);
        run_event("off0",     300, 4,  300, 1000, 5,  -1, -1, 1'b1);
        run_event("latetrig", 100, 6,  105, 1000, 20, 300, -1, 1'b1);
        run_event("divtrig",  100, 6,  104, 1000, 20, 20, -1, 1'b1);
        run_event("syncact",  90,  6,  93,  100, 30,  -1, 60, 1'b1);
        run_event("syncdiv",  90,  6,  94,  300, 30,  -1, 20, 1'b1);
        run_event("enlow",    200, 10, 207, 300, 15,  -1, -1, 1'b0);
        run_event("dur0",     10,  8,  15,  200, 0,   -1, -1, 1'b1);
        run_event("badtgt",   10,  8,  730, 200, 5,   -1, -1, 1'b1);
        run_event("tooth0",   10,  0,  10,  200, 5,   -1, -1, 1'b1);

        for (int i = 0; i < 30; i++) begin
            int ph;
            int th;
            int tg;
            ph = $urandom_range(0, 719);
            th = $urandom_range(1, 20);
            tg = (ph + $urandom_range(0, th + 2)) % 720;
            if ($urandom_range(0, 9) == 0) th = 0;
            if ($urandom_range(0, 9) == 0) tg = 720 + $urandom_range(0, 100);
            run_event($sformatf("rnd%0d", i), ph, th, tg, $urandom_range(50, 400),
                      $urandom_range(0, 40), -2, -2, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset while the pulse is high.
        @(negedge clk);
        eng_phase = 16'd90;
        next_tooth_length_deg = 16'd6;
        target_angle = 16'd93;
        tooth_period = 32'd100;
        duration = 32'd50;
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        repeat (55) @(posedge clk);
        #2;
        check_val("rst_pre_out", 64'(out), 64'd1);
        rst = 1'b1;
        #1;
        check_val("rst_async_out", 64'(out), 64'd0);
        check_val("rst_async_busy", 64'(busy), 64'd0);
        check_val("rst_async_dly", 64'(delay_cycles), 64'd0);
        exp_dly = 0;
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
        trigger = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_noenable_busy", 64'(busy), 64'd0);
        @(negedge clk);
        trigger = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_noenable_busy2", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/angle_event_scheduler.md
Name: angle_event_scheduler

Overview:
- Schedules one angle-referenced output pulse per engine cycle, e.g. an injector or coil drive.
- Consumes the crank-decoder outputs: tooth trigger strobe, synced, eng_phase, next_tooth_length_deg and tooth_period.
- On each tooth it checks whether the target angle falls inside the tooth now starting. If so, it interpolates the delay in clocks with a sequential divider, waits, then drives the output for a programmed number of clocks.

Parameters:
- CYCLE_DEG, 720, degrees per engine cycle; angle wrap modulus.
- DIV_BITS, 48, width of offset*period product; divider iterations.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- trigger  in  1  one-clock tooth strobe from decoder
- synced  in  1  decoder sync flag
- eng_phase  in  16  angle at current tooth, degrees
- next_tooth_length_deg  in  16  angular length of tooth now starting
- tooth_period  in  32  last tooth duration, clocks
- enable  in  1  arm scheduler
- target_angle  in  16  event angle, degrees, 0..CYCLE_DEG-1
- duration  in  32  output pulse width, clocks
- out  out  1  scheduled output
- busy  out  1  state != IDLE
- fired  out  1  one-clock pulse on out rising
- done  out  1  one-clock pulse on normal out falling
- abort  out  1  one-clock pulse on sync-loss abort
- late  out  1  one-clock pulse when fire is later than computed delay
- delay_cycles  out  32  last computed quotient (debug)

Behaviour:
- Reset: async. All outputs and registers go to 0, state IDLE. Reset mid-operation drops out immediately.
- States: IDLE, CHECK, DIVIDE, DELAY, ACTIVE. Edge T0 is the edge at which trigger is sampled.
- IDLE: if trigger && synced && enable at T0, latch phase, tooth length, period, target and duration. Clear elapsed counter to 0, go to CHECK. The elapsed counter then increments every clock (32-bit, saturating).
- CHECK (edge T0+1):
  - If target >= CYCLE_DEG, or phase >= CYCLE_DEG, or tooth length == 0, go to IDLE with no outputs.
  - offset = target-phase if target >= phase, else target+CYCLE_DEG-phase.
  - If offset >= tooth length, go to IDLE. Otherwise load product = offset*period (DIV_BITS wide) and go to DIVIDE.
- DIVIDE: restoring division, one quotient bit per clock, DIV_BITS clocks (edges T0+2..T0+49 at default).
  - Quotient = floor(product/tooth length). It is < period, so it fits 32 bits.
  - On completion, delay_cycles <= quotient and go to DELAY.
- DELAY: out <= 1, fired pulses and state goes to ACTIVE at edge T0+max(quotient, DIV_BITS+2). late pulses with fired when quotient < DIV_BITS+2.
- ACTIVE:
  - out held high for exactly max(duration,1) clocks.
  - Then out <= 0, done pulses, go to IDLE. A trigger arriving on that same edge is not accepted.
- Trigger while in CHECK, DIVIDE or DELAY: the tooth containing the target has ended. Fire at the next edge (go to ACTIVE, fired and late pulse); the divide is abandoned and delay_cycles is unchanged.
- Trigger in ACTIVE is ignored.
- synced low in any non-IDLE state: at the next edge out <= 0, abort pulses, go to IDLE, no done. This has priority over all other transitions.
- enable low after arming does not abort; the event completes. New arming needs enable high.
- Inputs other than synced/trigger are sampled only at T0; later changes do not affect an in-flight event.
- Pulse outputs never overlap except fired with late.

Test Plan:
- CYCLE_DEG=720, eng_phase=90, tooth=6, target=93, period=1000, duration=200, trigger at T0 -> delay_cycles=500; out high edges T0+500..T0+699; fired at T0+500, done at T0+700, late never.
- Wrap: eng_phase=714, tooth=12, target=2, period=4000 -> offset=8, delay_cycles=2666, out rises at T0+2666.
- Target outside tooth: eng_phase=90, tooth=6, target=96 -> returns to IDLE at T0+1; out, fired and delay_cycles stay 0.
- Late/early: target=eng_phase (offset 0) -> out rises at T0+50 with late. Separately, period=1000, target 5 of 6 deg, second trigger at T0+300 -> out rises at T0+301 with fired+late.
- Sync loss: drop synced during ACTIVE -> out low next edge, abort pulse, no done. Repeat during DIVIDE -> abort, out never rises.
- Reset: assert rst asynchronously mid-ACTIVE -> out low without a clock edge; after release, busy=0 and trigger with enable=0 leaves busy=0.
